// File: rtl/bus_read_sequencer.sv
// bus_read_sequencer: bursts wrap-around register words onto a valid/ready bus (in: clk reset src_data req start_sel count bus_ready; out: bus_data bus_valid cur_sel busy done)
module bus_read_sequencer #(
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      req,
  input  logic [SEL_W-1:0]          start_sel,
  input  logic [SEL_W:0]            count,
  input  logic                      bus_ready,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      bus_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      busy,
  output logic                      done
);
  typedef enum logic {S_IDLE, S_SEND} state_t;
  localparam logic [SEL_W:0] NSRC = (SEL_W+1)'(NUM_SRC);
  state_t              r_state, w_next;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W:0]      r_remaining;
  logic [DATA_W-1:0]   r_data;
  logic                r_done;
  logic                w_start, w_beat, w_last;
  logic [SEL_W:0]      w_ss, w_diff, w_cnt;
  logic [SEL_W-1:0]    w_red, w_nsel, w_idx;
  logic [DATA_W-1:0]   w_words [NUM_SRC];
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_w
    assign w_words[g] = src_data[g*DATA_W +: DATA_W];
  end
  always_comb begin
    w_ss    = {1'b0, start_sel};
    w_diff  = w_ss - NSRC;
    w_red   = w_ss < NSRC ? start_sel : (w_diff < NSRC ? w_diff[SEL_W-1:0] : '0);
    w_cnt   = count > NSRC ? NSRC : count;
    w_nsel  = r_sel == SEL_W'(NUM_SRC - 1) ? '0 : r_sel + SEL_W'(1);
    w_start = r_state == S_IDLE && req && count != '0;
    w_beat  = r_state == S_SEND && bus_ready;
    w_last  = w_beat && r_remaining == (SEL_W+1)'(1);
    w_idx   = w_start ? w_red : w_nsel;
  end
  always_ff @(posedge clk) r_state <= reset ? S_IDLE : w_next;
  always_comb w_next = w_start ? S_SEND : (w_last ? S_IDLE : r_state);
  always_comb begin
    busy      = r_state == S_SEND;
    bus_valid = r_state == S_SEND;
    bus_data  = r_data;
    cur_sel   = r_sel;
    done      = r_done;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel       <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start) begin
        r_sel       <= w_red;
        r_remaining <= w_cnt;
        r_data      <= w_words[w_idx];
      end else if (w_beat && !w_last) begin
        r_sel       <= w_nsel;
        r_remaining <= r_remaining - (SEL_W+1)'(1);
        r_data      <= w_words[w_idx];
      end else if (w_last) begin
        r_remaining <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bus_read_sequencer.sv
// tb_bus_read_sequencer: random and directed stimulus checked against a queue-based burst model
module tb_bus_read_sequencer;
  localparam int N = 8, SW = 3, DW = 16;
  logic            clk = 0, reset = 1, req = 0, bus_ready = 0;
  logic [N*DW-1:0] src_data = '0;
  logic [SW-1:0]   start_sel = '0;
  logic [SW:0]     count = '0;
  logic [DW-1:0]   bus_data;
  logic            bus_valid, busy, done;
  logic [SW-1:0]   cur_sel;
  int vectors = 0, miscompares = 0;
  int m_q[$];
  int m_sel = 0;
  logic [DW-1:0] m_data = '0;
  bit m_busy = 0, m_done = 0;
  bus_read_sequencer #(.NUM_SRC(N), .SEL_W(SW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .req(req), .start_sel(start_sel),
    .count(count), .bus_ready(bus_ready), .bus_data(bus_data), .bus_valid(bus_valid),
    .cur_sel(cur_sel), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] word(int i);
    return src_data[i*DW +: DW];
  endfunction
  task automatic chk(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_q.delete(); m_sel = 0; m_data = '0; m_busy = 0; m_done = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (req && count != 0) begin
        int s, n;
        s = start_sel;
        if (s >= N) s = (s - N < N) ? s - N : 0;
        n = (count > N) ? N : int'(count);
        for (int i = 0; i < n; i++) m_q.push_back((s + i) % N);
        m_sel = m_q.pop_front(); m_data = word(m_sel); m_busy = 1;
      end
    end else begin
      m_done = 0;
      if (bus_ready) begin
        if (m_q.size() == 0) begin m_busy = 0; m_done = 1; end
        else begin m_sel = m_q.pop_front(); m_data = word(m_sel); end
      end
    end
    #1;
    chk("model_busy", busy, m_busy);
    chk("model_valid", bus_valid, m_busy);
    chk("model_done", done, m_done);
    chk("model_sel", cur_sel, m_sel);
    if (m_busy) chk("model_data", bus_data, m_data);
  end
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic go(int s, int c);
    req = 1; start_sel = SW'(s); count = (SW+1)'(c);
    tick(); req = 0;
  endtask
  initial begin
    int exp_w[8] = '{6, 7, 0, 1, 2, 3, 4, 5};
    for (int k = 0; k < N; k++) src_data[k*DW +: DW] = DW'(16'h1000 + k);
    tick(2); reset = 0;
    chk("rst_valid", bus_valid, 0); chk("rst_busy", busy, 0);
    chk("rst_sel", cur_sel, 0); chk("rst_done", done, 0); chk("rst_data", bus_data, 0);
    bus_ready = 1; go(2, 1);
    chk("single_valid", bus_valid, 1); chk("single_data", bus_data, 16'h1002); chk("single_sel", cur_sel, 2);
    tick(); chk("single_done", done, 1); chk("single_novalid", bus_valid, 0); chk("single_busy", busy, 0);
    tick(); chk("single_done_clr", done, 0);
    bus_ready = 0; go(1, 3);
    chk("bp_w0a", bus_data, 16'h1001); tick();
    chk("bp_w0b", bus_data, 16'h1001); tick();
    chk("bp_w0c", bus_data, 16'h1001); bus_ready = 1; tick();
    chk("bp_w1", bus_data, 16'h1002); tick();
    chk("bp_w2", bus_data, 16'h1003); tick();
    chk("bp_done", done, 1);
    go(6, 9);
    for (int i = 0; i < 8; i++) begin
      chk("wrap_sel", cur_sel, exp_w[i]); chk("wrap_data", bus_data, 16'h1000 + exp_w[i]);
      chk("wrap_done_low", done, 0); tick();
    end
    chk("wrap_done", done, 1);
    go(3, 0); chk("cnt0_valid", bus_valid, 0); chk("cnt0_busy", busy, 0);
    tick(); chk("cnt0_done", done, 0);
    go(0, 2); req = 1; start_sel = 5; count = 5;
    chk("midreq_sel0", cur_sel, 0); tick(); req = 0;
    chk("midreq_sel1", cur_sel, 1); tick();
    chk("midreq_done", done, 1); tick();
    chk("midreq_idle", busy, 0); chk("midreq_nodone", done, 0);
    go(3, 1); chk("b2b_first", bus_data, 16'h1003); tick();
    chk("b2b_done", done, 1); go(5, 2);
    chk("b2b_valid", bus_valid, 1); chk("b2b_data", bus_data, 16'h1005); tick(2);
    chk("b2b_done2", done, 1);
    go(0, 4); reset = 1; tick(); reset = 0;
    chk("rstmid_valid", bus_valid, 0); chk("rstmid_busy", busy, 0); chk("rstmid_sel", cur_sel, 0);
    chk("rstmid_data", bus_data, 0); chk("rstmid_done", done, 0);
    tick(); chk("rstmid_nodone", done, 0);
    go(4, 1); chk("after_rst_data", bus_data, 16'h1004);
    for (int c = 0; c < 3000; c++) begin
      req = ($urandom_range(0, 3) == 0);
      start_sel = SW'($urandom_range(0, N - 1));
      count = (SW+1)'($urandom_range(0, 15));
      bus_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0)
        src_data[$urandom_range(0, N - 1)*DW +: DW] = DW'($urandom);
      tick();
    end
    reset = 0; req = 0; tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
